// File: rtl/oppm_pkg.sv
// oppm_pkg: shared types and sizing helpers for the OPPM receive path.
package oppm_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;
  function automatic int slots_per_sym(input int n);
    return 1 << n;
  endfunction
  function automatic int cnt_w(input int x);
    return $clog2(x + 1);
  endfunction
endpackage

// File: rtl/oppm_slot_timer.sv
// oppm_slot_timer: tick/slot counters framing one symbol; hold pins both at zero.
module oppm_slot_timer
  import oppm_pkg::*;
#(
  parameter int N = 2,
  parameter int L = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  output logic [N-1:0] slot_ct,
  output logic         se
);
  localparam int TW = cnt_w(L - 1);
  localparam logic [TW-1:0] T_MAX = TW'(L - 1);
  localparam logic [N-1:0] S_MAX = N'(slots_per_sym(N) - 1);
  logic [TW-1:0] tick_ct;
  logic          wrap;
  assign wrap = tick_ct == T_MAX;
  assign se   = wrap && slot_ct == S_MAX;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_ct <= '0;
      slot_ct <= '0;
    end else if (hold) begin
      tick_ct <= '0;
      slot_ct <= '0;
    end else begin
      tick_ct <= wrap ? '0 : tick_ct + 1'b1;
      slot_ct <= wrap ? slot_ct + 1'b1 : slot_ct;
    end
  end
endmodule

// File: rtl/oppm_decoder.sv
// oppm_decoder: OPPM pulse-stream demodulator with preamble lock and erasure reporting.
// Define OPPM_DEC_SYNC_EN to pass pulse_in through a two-flop synchronizer first.
module oppm_decoder
  import oppm_pkg::*;
#(
  parameter int N        = 2,
  parameter int L        = 4,
  parameter int PULSE_CT = 1,
  parameter int PRE_CT   = 3,
  parameter int MISS_MAX = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pulse_in,
  output logic [N-1:0] data,
  output logic         valid,
  output logic         erasure,
  output logic         collision,
  output logic         locked
);
  localparam int PW = cnt_w(PRE_CT);
  localparam int MW = cnt_w(MISS_MAX);
  localparam logic [PW-1:0] PRE_MAX   = PW'(PRE_CT);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);

  if (L <= PULSE_CT || PRE_CT < 1 || MISS_MAX < 1) begin : g_cfg_err
    $error("oppm_decoder: illegal parameter set");
  end

  logic          p, p_q, ev, se, hold;
  logic          got, extra, got_eff, extra_eff, good;
  logic [N-1:0]  slot_ct, cap, slot_eff;
  logic [PW-1:0] pre_ct;
  logic [MW-1:0] miss_ct;
  state_t        state;

`ifdef OPPM_DEC_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], pulse_in};
  end
  assign p = sync_q[1];
`else
  assign p = pulse_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= 1'b0;
    else p_q <= p;
  end

  assign ev   = p & ~p_q;
  assign hold = state == IDLE && !ev;

  oppm_slot_timer #(.N(N), .L(L)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .slot_ct(slot_ct),
    .se     (se)
  );

  // An edge landing on the SE cycle still belongs to the symbol being closed.
  assign got_eff   = got | ev;
  assign slot_eff  = got ? cap : slot_ct;
  assign extra_eff = extra | (got & ev);
  assign good      = got_eff && slot_eff == '0 && !extra_eff;
  assign locked    = state == LOCKED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      got   <= 1'b0;
      extra <= 1'b0;
      cap   <= '0;
    end else if (se) begin
      got   <= 1'b0;
      extra <= 1'b0;
    end else if (ev) begin
      cap   <= got ? cap : slot_ct;
      got   <= 1'b1;
      extra <= got;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pre_ct    <= '0;
      miss_ct   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      erasure   <= 1'b0;
      collision <= 1'b0;
    end else begin
      valid     <= 1'b0;
      erasure   <= 1'b0;
      collision <= 1'b0;
      case (state)
        IDLE: if (ev) begin
          state  <= PRE_CT == 1 ? LOCKED : SYNC;
          pre_ct <= PW'(1);
        end
        SYNC: if (se) begin
          state  <= !good ? IDLE : pre_ct == PRE_MAX ? LOCKED : SYNC;
          pre_ct <= (!good || pre_ct == PRE_MAX) ? '0 : pre_ct + 1'b1;
        end
        LOCKED: if (se) begin
          if (got_eff) begin
            valid     <= 1'b1;
            data      <= slot_eff;
            collision <= extra_eff;
            miss_ct   <= '0;
          end else begin
            erasure <= 1'b1;
            miss_ct <= miss_ct == MISS_LAST ? '0 : miss_ct + 1'b1;
            state   <= miss_ct == MISS_LAST ? IDLE : LOCKED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oppm_decoder.sv
// tb_oppm_decoder: directed symbol-stream bench for oppm_decoder (N=2, L=4, 16-tick symbols).
module tb_oppm_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pulse_in = 1'b0;
  logic [1:0] data;
  logic       valid, erasure, collision, locked;
  int         tests = 0;
  int         fails = 0;

`ifdef OPPM_DEC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // One bit per tick of a 16-tick symbol; bit 4*v is tick 0 of slot v.
  localparam logic [15:0] P0  = 16'h0001;
  localparam logic [15:0] V1  = 16'h0010;
  localparam logic [15:0] V2  = 16'h0100;
  localparam logic [15:0] V3  = 16'h1000;
  localparam logic [15:0] E   = 16'h0000;
  localparam logic [15:0] COL = 16'h1010;
  localparam logic [15:0] SEP = 16'h8000;

  oppm_decoder #(.N(2), .L(4), .PULSE_CT(1), .PRE_CT(3), .MISS_MAX(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .data     (data),
    .valid    (valid),
    .erasure  (erasure),
    .collision(collision),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  logic       s_valid, s_er, s_coll, s_lock, s1_strobe;
  logic [1:0] s_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one symbol; snapshots the strobe produced by the previous symbol's SE.
  task automatic sym(input logic [15:0] pat);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == LAT) begin
        s_valid = valid;
        s_data  = data;
        s_coll  = collision;
        s_er    = erasure;
        s_lock  = locked;
      end
      if (i == LAT + 1) s1_strobe = valid | erasure;
      pulse_in = pat[i];
    end
  endtask

  task automatic snap(input string tag, input logic v, input logic [1:0] d,
                      input logic c, input logic e, input logic l);
    check({tag, ".valid"}, s_valid, v);
    if (v) check({tag, ".data"}, s_data, d);
    check({tag, ".collision"}, s_coll, c);
    check({tag, ".erasure"}, s_er, e);
    check({tag, ".locked"}, s_lock, l);
    check({tag, ".one_cycle"}, s1_strobe, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst.data", data, 0);
    check("rst.valid", valid, 0);
    check("rst.erasure", erasure, 0);
    check("rst.collision", collision, 0);
    check("rst.locked", locked, 0);
    rst_n = 1'b1;
    sym(P0); sym(P0); snap("pre2", 0, 0, 0, 0, 0);
    sym(P0); snap("pre3", 0, 0, 0, 0, 0);
    sym(V2); snap("lock_rise", 0, 0, 0, 0, 1);
    sym(V1); snap("d2", 1, 2, 0, 0, 1);
    sym(V3); snap("d1", 1, 1, 0, 0, 1);
    sym(E); snap("d3", 1, 3, 0, 0, 1);
    sym(V3); snap("miss_a", 0, 0, 0, 1, 1);
    sym(COL); snap("after_miss", 1, 3, 0, 0, 1);
    sym(SEP); snap("coll", 1, 1, 1, 0, 1);
    sym(V2); snap("se_edge", 1, 3, 0, 0, 1);
    sym(P0); snap("d2b", 1, 2, 0, 0, 1);
    sym(E); snap("zero", 1, 0, 0, 0, 1);
    sym(E); snap("miss1", 0, 0, 0, 1, 1);
    sym(P0); snap("miss2_drop", 0, 0, 0, 1, 0);
    sym(V1); snap("bad_p1", 0, 0, 0, 0, 0);
    sym(P0); snap("bad_p2", 0, 0, 0, 0, 0);
    sym(P0); snap("re_p1", 0, 0, 0, 0, 0);
    sym(P0); snap("re_p2", 0, 0, 0, 0, 0);
    sym(V1); snap("relock", 0, 0, 0, 0, 1);
    sym(V3); snap("re_d1", 1, 1, 0, 0, 1);
    repeat (6) begin
      @(negedge clk);
      pulse_in = 1'b0;
    end
    check("pre_rst.data", data, 3);
    check("pre_rst.locked", locked, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.data", data, 0);
    check("mid_rst.locked", locked, 0);
    check("mid_rst.valid", valid, 0);
    check("mid_rst.erasure", erasure, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sym(P0); sym(P0); sym(P0); snap("rst_p3", 0, 0, 0, 0, 0);
    sym(V2); snap("rst_lock", 0, 0, 0, 0, 1);
    sym(E); snap("rst_d2", 1, 2, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/oppm_decoder.md
Name: oppm_decoder

Overview:
- Receive side of the OPPM link: demodulates the single-wire pulse stream produced by the OPPM encoder/modulator back into N-bit symbols.
- Acquires symbol timing from a preamble of all-zero symbols, confirms lock, then emits one decoded symbol per symbol period.
- Sits between the line input (pulse_in) and the packet deframer.

Parameters:
- N, 2, symbol size in bits; 2**N slots per symbol.
- L, 4, slot width in clock ticks; must be greater than PULSE_CT.
- PULSE_CT, 1, transmitted pulse width in ticks; only constrains L.
- PRE_CT, 3, number of zero preamble symbols; must be 1 or more.
- MISS_MAX, 2, consecutive empty symbols tolerated in LOCKED before lock is dropped; must be 1 or more.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous reset, active low.
- pulse_in  input  1  received OPPM pulse, level signal.
- data  output  N  last decoded symbol; held between valid strobes.
- valid  output  1  one-cycle strobe: data holds a new symbol.
- erasure  output  1  one-cycle strobe: a LOCKED symbol period contained no pulse.
- collision  output  1  qualifies valid: more than one pulse in that symbol; data is the first pulse.
- locked  output  1  preamble confirmed; data symbols are being emitted.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: data=0, valid=0, erasure=0, collision=0, locked=0, state IDLE, all counters 0.
- An event is a rising edge of pulse_in: pulse_in=1 this cycle and 0 in the previous cycle. The previous-value register resets to 0.
- Timers:
  - tick_ct runs 0..L-1 and wraps.
  - slot_ct runs 0..2**N-1 and increments when tick_ct wraps.
  - Symbol end (SE) is tick_ct==L-1 and slot_ct==2**N-1.
- Within one symbol period:
  - The first event captures slot_ct, sets got, and clears extra.
  - Further events set extra.
  - An event in the same cycle as SE belongs to the current symbol.
- At SE, the current symbol is evaluated. In the next cycle got and extra are cleared. An event in that next cycle is captured normally for the new symbol.
- State IDLE:
  - locked=0 and the timers are held at 0.
  - On an event, that cycle is tick 0 / slot 0 of symbol 0. Next cycle: tick_ct=1, slot_ct=0, got=1, captured slot=0.
  - If PRE_CT==1 go directly to LOCKED; otherwise go to SYNC with pre_ct=1.
- State SYNC:
  - At SE with got=1, captured slot==0 and extra=0: increment pre_ct. When pre_ct reaches PRE_CT go to LOCKED, with locked=1 from the next cycle.
  - At SE with any other outcome (empty, nonzero slot, or extra) go to IDLE.
  - No valid or erasure strobes are produced in SYNC.
- State LOCKED:
  - At SE with got=1: next cycle valid=1, data=captured slot, collision=extra, miss_ct=0.
  - At SE with got=0: next cycle erasure=1 and miss_ct increments.
  - If miss_ct reaches MISS_MAX: go to IDLE and drop locked in the same cycle as that final erasure strobe.
- Latency: the valid or erasure strobe appears exactly 1 cycle after SE, i.e. L*2**N ticks after that symbol's tick 0.
- The first LOCKED symbol is the one immediately after the PRE_CT-th preamble symbol. Zero-valued data symbols are legal there.
- valid and erasure are never asserted together. collision=0 whenever valid=0.
- Counter width is $clog2(X+1) for each bound X.
- Reset asserted mid-symbol clears immediately. After reset release the block waits for a fresh event in IDLE.

Optional Feature:
- Macro OPPM_DEC_SYNC_EN.
- Defined: pulse_in passes through a two-flop synchronizer (reset to 0) before edge detection. All event-relative timing is unchanged. Absolute latency from the pin increases by 2 cycles.
- Undefined: pulse_in is used directly and must already be synchronous to clk.

Decomposition:
- Package oppm_pkg:
  - state enum (IDLE, SYNC, LOCKED).
  - function slots_per_sym(N) returning 2**N.
  - function width helper wrapping $clog2(X+1).
- Tick, slot, pre and miss counters use the existing Counter module. The data output uses the existing Register module.
- One natural sub-module, oppm_slot_timer, holds tick_ct and slot_ct with a hold/align input. It outputs slot_ct and SE.

Test Plan (N=2, L=4, PRE_CT=3, MISS_MAX=2, PULSE_CT=1; symbol period 16 ticks):
- Three zero preamble symbols from the encoder, then symbols 2, 1, 3: locked rises 1 cycle after the 3rd preamble SE. valid strobes with data=2, 1, 3, each 16 cycles apart; collision=0.
- Preamble whose 2nd symbol has its pulse in slot 1: return to IDLE, locked stays 0, no strobes. The next clean 3-symbol preamble locks.
- LOCKED, one empty symbol then a symbol with value 3: erasure strobe, then valid with data=3, locked stays 1. Two consecutive empty symbols: two erasures, and locked=0 in the cycle of the 2nd erasure.
- LOCKED, pulses in slot 1 and slot 3 of the same symbol: valid with data=1 and collision=1.
- Pulse edge at tick 3 of slot 3 (the SE cycle), no earlier pulse in that symbol: valid with data=3. An edge one cycle later is captured as slot 0 of the next symbol.
- rst_n pulsed low mid-symbol in LOCKED: all outputs 0 immediately. Relock requires a full 3-symbol preamble. With OPPM_DEC_SYNC_EN defined, the same stimulus gives the same decoded data with 2 extra cycles of latency.
